key_search: RTL and testbench

Key-search controller for the ARC4 cracking datapath; sits directly upstream of `arc4`. It drives candidate 24-bit keys into `arc4` one at a time and handshakes each decryption run. After each run it reads back the plaintext memory and checks that every message byte is printable ASCII. It stops on the first passing key or when the key space is exhausted. Parallel cracking instantiates several copies with different `KEY_START` and a shared `KEY_STEP`.

---
 rtl/key_search.sv | 138 +++++++++++++
 tb/tb_key_search.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search.sv
// key_search: walks 24-bit candidate keys through arc4. After each decryption
// run it reads the plaintext back: byte 0 is the length, bytes 1..len must all
// be printable ASCII (8'h20..8'h7E). It stops on the first passing key, or when
// the next candidate would overflow 24 bits.
//
// Handshake: arc4_en is a one-cycle start pulse. The run is in progress once
// arc4_rdy has been seen low, and it is complete when arc4_rdy is seen high again.
// The key is held stable from the pulse until the run is complete.
module key_search #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_STEP  = 24'h000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic        arc4_en,
  input  logic        arc4_rdy,
  output logic [23:0] arc4_key,
  output logic        chk_active,
  output logic [7:0]  chk_addr,
  input  logic [7:0]  pt_rddata,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    WAIT_BUSY = 4'd2,
    WAIT_DONE = 4'd3,
    LEN_RD    = 4'd4,
    LEN_WAIT  = 4'd5,
    CHR_RD    = 4'd6,
    CHR_EVAL  = 4'd7,
    NEXT_KEY  = 4'd8,
    DONE      = 4'd9
  } state_t;

  state_t      state, state_nx;
  logic [23:0] key_nx;
  logic        key_valid_nx;
  logic [7:0]  len, len_nx;
  logic [7:0]  idx, idx_nx;
  logic [24:0] key_sum;
  logic        printable;

  // Bit 24 of the sum flags that the key space is exhausted.
  assign key_sum   = {1'b0, key} + {1'b0, KEY_STEP};
  assign printable = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);

  // State and datapath registers; arc4_en is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key       <= KEY_START;
      key_valid <= 1'b0;
      len       <= 8'd0;
      idx       <= 8'd0;
      arc4_en   <= 1'b0;
    end else begin
      state     <= state_nx;
      key       <= key_nx;
      key_valid <= key_valid_nx;
      len       <= len_nx;
      idx       <= idx_nx;
      arc4_en   <= (state_nx == START);
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nx     = state;
    key_nx       = key;
    key_valid_nx = key_valid;
    len_nx       = len;
    idx_nx       = idx;
    case (state)
      IDLE: begin
        if (en) begin
          key_nx       = KEY_START;
          key_valid_nx = 1'b0;
          state_nx     = START;
        end
      end
      START:     state_nx = WAIT_BUSY;
      WAIT_BUSY: if (!arc4_rdy) state_nx = WAIT_DONE;
      WAIT_DONE: if (arc4_rdy)  state_nx = LEN_RD;
      LEN_RD:    state_nx = LEN_WAIT;
      LEN_WAIT: begin
        len_nx = pt_rddata;
        idx_nx = 8'd1;
        if (pt_rddata == 8'd0) begin
          // An empty message passes vacuously.
          key_valid_nx = 1'b1;
          state_nx     = DONE;
        end else begin
          state_nx = CHR_RD;
        end
      end
      CHR_RD:    state_nx = CHR_EVAL;
      CHR_EVAL: begin
        if (!printable) begin
          state_nx = NEXT_KEY;
        end else if (idx == len) begin
          key_valid_nx = 1'b1;
          state_nx     = DONE;
        end else begin
          idx_nx   = idx + 8'd1;
          state_nx = CHR_RD;
        end
      end
      NEXT_KEY: begin
        if (key_sum[24]) begin
          state_nx = DONE;
        end else begin
          key_nx   = key_sum[23:0];
          state_nx = START;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    rdy        = (state == IDLE);
    chk_active = (state == LEN_RD) || (state == LEN_WAIT) ||
                 (state == CHR_RD) || (state == CHR_EVAL);
    chk_addr   = 8'd0;
    if ((state == CHR_RD) || (state == CHR_EVAL)) chk_addr = idx;
    arc4_key   = key;
    dbg_state  = state;
  end

endmodule

// File: tb/tb_key_search.sv
// Bench for key_search: three instances (different start/step), each with a
// behavioural arc4 + plaintext memory whose contents depend on the key used.
module tb_key_search;

  logic        clk;
  logic        rst_n;
  logic        en_v         [3];
  logic        rdy_v        [3];
  logic [23:0] key_v        [3];
  logic        key_valid_v  [3];
  logic        arc4_en_v    [3];
  logic        arc4_rdy_v   [3];
  logic [23:0] arc4_key_v   [3];
  logic        chk_active_v [3];
  logic [7:0]  chk_addr_v   [3];
  logic [7:0]  pt_rddata_v  [3];
  logic [3:0]  dbg_v        [3];

  logic [23:0] start_of [3];
  logic [23:0] step_of  [3];

  // run context shared with the models
  int          cur;
  int          mode;
  logic [23:0] target;
  int          seed;
  int          busy_len;
  int          cnt     [3];
  logic [23:0] run_key [3];

  // scoreboard
  logic [23:0] exp_q [$];
  logic [23:0] log_q [$];
  logic [23:0] exp_key;
  logic        exp_valid;
  int          exp_chk;
  int          exp_max_addr;
  bit          mon_on;
  int          chk_cnt, max_addr, akey_err, inact_err;
  int          n_cmp, n_fail;

  key_search #(.KEY_START(24'h000000), .KEY_STEP(24'h000001)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .rdy(rdy_v[0]), .key(key_v[0]),
    .key_valid(key_valid_v[0]), .arc4_en(arc4_en_v[0]), .arc4_rdy(arc4_rdy_v[0]),
    .arc4_key(arc4_key_v[0]), .chk_active(chk_active_v[0]), .chk_addr(chk_addr_v[0]),
    .pt_rddata(pt_rddata_v[0]), .dbg_state(dbg_v[0]));

  key_search #(.KEY_START(24'hFFFFFE), .KEY_STEP(24'h000001)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .rdy(rdy_v[1]), .key(key_v[1]),
    .key_valid(key_valid_v[1]), .arc4_en(arc4_en_v[1]), .arc4_rdy(arc4_rdy_v[1]),
    .arc4_key(arc4_key_v[1]), .chk_active(chk_active_v[1]), .chk_addr(chk_addr_v[1]),
    .pt_rddata(pt_rddata_v[1]), .dbg_state(dbg_v[1]));

  key_search #(.KEY_START(24'hFFFFFE), .KEY_STEP(24'h000002)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .rdy(rdy_v[2]), .key(key_v[2]),
    .key_valid(key_valid_v[2]), .arc4_en(arc4_en_v[2]), .arc4_rdy(arc4_rdy_v[2]),
    .arc4_key(arc4_key_v[2]), .chk_active(chk_active_v[2]), .chk_addr(chk_addr_v[2]),
    .pt_rddata(pt_rddata_v[2]), .dbg_state(dbg_v[2]));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plaintext produced by arc4 for a given key: byte 0 = length.
  function automatic logic [7:0] pt_byte(int md, logic [23:0] tgt, logic [23:0] k,
                                         logic [7:0] a, int sd);
    logic [7:0] r;
    int unsigned h, ln, bad_pos;
    logic [7:0] bad [4];
    bad[0] = 8'h1F; bad[1] = 8'h7F; bad[2] = 8'h00; bad[3] = 8'hFF;
    r = 8'h00;
    case (md)
      0: case (a)  // "HELLO"; wrong keys carry a control char at index 3
           8'd0: r = 8'd5;
           8'd1: r = 8'h48;
           8'd2: r = 8'h45;
           8'd3: r = (k == tgt) ? 8'h4C : 8'h07;
           8'd4: r = 8'h4C;
           8'd5: r = 8'h4F;
           default: r = 8'h00;
         endcase
      1: case (a)
           8'd0: r = 8'd3;
           8'd1: r = 8'h20;
           8'd2: r = 8'h7E;
           8'd3: r = 8'h41;
           default: r = 8'h00;
         endcase
      2: if (k == tgt) begin
           case (a)
             8'd0: r = 8'd3;
             8'd1: r = 8'h41;
             8'd2: r = 8'h7F;
             8'd3: r = 8'h41;
             default: r = 8'h00;
           endcase
         end else begin
           case (a)
             8'd0: r = 8'd1;
             8'd1: r = 8'h41;
             default: r = 8'h00;
           endcase
         end
      3: r = 8'h00;
      4: case (a)
           8'd0: r = 8'd2;
           8'd1: r = 8'h41;
           8'd2: r = 8'h01;
           default: r = 8'h00;
         endcase
      default: begin
        h  = k * 13 + sd;
        ln = h % 8;
        if (a == 8'd0) r = 8'(ln);
        else if (a > ln) r = 8'h00;
        else begin
          bad_pos = (ln == 0) ? 0 : ((k + sd) % ln) + 1;
          if (k != tgt && a == bad_pos) r = bad[k % 4];
          else r = 8'h20 + 8'((k * 31 + a * 17 + sd) % 95);
        end
      end
    endcase
    return r;
  endfunction

  // Behavioural arc4 + plaintext memory (1-cycle read latency), per instance.
  always @(posedge clk or negedge rst_n) begin
    for (int j = 0; j < 3; j++) begin
      if (!rst_n) begin
        arc4_rdy_v[j]  <= 1'b1;
        cnt[j]         <= 0;
        run_key[j]     <= 24'h0;
        pt_rddata_v[j] <= 8'h00;
      end else begin
        if (arc4_en_v[j]) begin
          arc4_rdy_v[j] <= 1'b0;
          cnt[j]        <= busy_len;
          run_key[j]    <= arc4_key_v[j];
        end else if (!arc4_rdy_v[j]) begin
          if (cnt[j] == 0) arc4_rdy_v[j] <= 1'b1;
          else cnt[j] <= cnt[j] - 1;
        end
        pt_rddata_v[j] <= pt_byte(mode, target, run_key[j], chk_addr_v[j], seed);
      end
    end
  end

  // Monitor for the instance under test, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (arc4_en_v[cur]) log_q.push_back(arc4_key_v[cur]);
      if (chk_active_v[cur]) begin
        chk_cnt++;
        if (int'(chk_addr_v[cur]) > max_addr) max_addr = int'(chk_addr_v[cur]);
      end else if (chk_addr_v[cur] != 8'd0) begin
        inact_err++;
      end
      if (arc4_key_v[cur] != key_v[cur]) akey_err++;
    end
  end

  // ---------------- reference model ----------------
  // Walks the key sequence from the rules: try key, check bytes 1..len,
  // stop on pass or when key+step leaves the 24-bit range.
  task automatic ref_search(int j);
    longint k;
    int ln, n;
    bit ok;
    logic [7:0] c;
    exp_q.delete();
    exp_chk = 0;
    exp_max_addr = 0;
    k = longint'(start_of[j]);
    for (int guard = 0; guard < 64; guard++) begin
      exp_q.push_back(k[23:0]);
      ln = int'(pt_byte(mode, target, k[23:0], 8'd0, seed));
      ok = 1'b1;
      n  = 0;
      for (int i = 1; i <= ln; i++) begin
        n = i;
        c = pt_byte(mode, target, k[23:0], 8'(i), seed);
        if (c < 8'h20 || c > 8'h7E) begin ok = 1'b0; break; end
      end
      exp_chk += 2 + 2 * n;
      if (n > exp_max_addr) exp_max_addr = n;
      exp_key = k[23:0];
      if (ok) begin exp_valid = 1'b1; break; end
      if (k + longint'(step_of[j]) > 64'hFFFFFF) begin exp_valid = 1'b0; break; end
      k = k + longint'(step_of[j]);
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_one(int j, int md, logic [23:0] tg, bit use_tab,
                         logic [23:0] tab_key, logic tab_valid, int tab_tries, bit busy_en);
    int w;
    @(negedge clk);
    for (w = 0; w < 20 && !rdy_v[j]; w++) @(negedge clk);
    cur = j; mode = md; target = tg; seed = int'($urandom_range(0, 1000));
    busy_len = int'($urandom_range(1, 6));
    ref_search(j);
    log_q.delete();
    chk_cnt = 0; max_addr = 0; akey_err = 0; inact_err = 0;
    mon_on = 1'b1;
    en_v[j] = 1'b1;
    @(negedge clk);
    en_v[j] = 1'b0;
    chk("rdy_fall", 32'(rdy_v[j]), 32'd0);
    for (w = 0; w < 5000; w++) begin
      if (rdy_v[j]) break;
      if (busy_en) en_v[j] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    en_v[j] = 1'b0;
    mon_on = 1'b0;
    chk("done_timeout", 32'(w < 5000), 32'd1);
    chk("key", 32'(key_v[j]), 32'(exp_key));
    chk("key_valid", 32'(key_valid_v[j]), 32'(exp_valid));
    if (use_tab) begin
      chk("tab_key", 32'(key_v[j]), 32'(tab_key));
      chk("tab_valid", 32'(key_valid_v[j]), 32'(tab_valid));
      chk("tab_tries", 32'(log_q.size()), 32'(tab_tries));
    end
    chk("tries", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk("key_seq", 32'(log_q[i]), 32'(exp_q[i]));
    chk("chk_cycles", 32'(chk_cnt), 32'(exp_chk));
    chk("max_addr", 32'(max_addr), 32'(exp_max_addr));
    chk("arc4_key_eq", 32'(akey_err), 32'd0);
    chk("addr_inactive", 32'(inact_err), 32'd0);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_rdy"}, 32'(rdy_v[0]), 32'd1);
    chk({tag, "_key"}, 32'(key_v[0]), 32'h000000);
    chk({tag, "_key1"}, 32'(key_v[1]), 32'hFFFFFE);
    chk({tag, "_key_valid"}, 32'(key_valid_v[0]), 32'd0);
    chk({tag, "_arc4_en"}, 32'(arc4_en_v[0]), 32'd0);
    chk({tag, "_chk_active"}, 32'(chk_active_v[0]), 32'd0);
    chk({tag, "_chk_addr"}, 32'(chk_addr_v[0]), 32'd0);
  endtask

  typedef struct {
    int          inst;
    int          md;
    logic [23:0] tgt;
    logic [23:0] exp_key;
    logic        exp_valid;
    int          exp_tries;
  } vec_t;

  vec_t tab [7];

  initial begin
    int w;
    tab[0] = '{0, 0, 24'h000003, 24'h000003, 1'b1, 4};  // HELLO on key 3
    tab[1] = '{0, 1, 24'h000000, 24'h000000, 1'b1, 1};  // 20/7E boundaries pass
    tab[2] = '{0, 2, 24'h000000, 24'h000001, 1'b1, 2};  // 7F rejects key 0
    tab[3] = '{0, 3, 24'h000000, 24'h000000, 1'b1, 1};  // empty message
    tab[4] = '{1, 4, 24'h000000, 24'hFFFFFF, 1'b0, 2};  // exhaustion, step 1
    tab[5] = '{2, 4, 24'h000000, 24'hFFFFFE, 1'b0, 1};  // exhaustion, step 2
    tab[6] = '{1, 0, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 2};  // last key passes
    start_of[0] = 24'h000000; step_of[0] = 24'h000001;
    start_of[1] = 24'hFFFFFE; step_of[1] = 24'h000001;
    start_of[2] = 24'hFFFFFE; step_of[2] = 24'h000002;
    n_cmp = 0; n_fail = 0; mon_on = 1'b0;
    cur = 0; mode = 0; target = 24'h3; seed = 0; busy_len = 2;
    for (int j = 0; j < 3; j++) en_v[j] = 1'b0;

    // asynchronous reset: outputs settle before any clock edge
    rst_n = 1'b1;
    #12 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++)
      run_one(tab[t].inst, tab[t].md, tab[t].tgt, 1'b1,
              tab[t].exp_key, tab[t].exp_valid, tab[t].exp_tries, 1'b0);

    // en toggled while busy must not disturb the key sequence
    run_one(0, 0, 24'h000003, 1'b1, 24'h000003, 1'b1, 4, 1'b1);

    // reset while waiting on the second key's arc4 run
    @(negedge clk);
    cur = 0; mode = 0; target = 24'h000003; busy_len = 6;
    en_v[0] = 1'b1;
    @(negedge clk);
    en_v[0] = 1'b0;
    for (w = 0; w < 500; w++) begin
      if (key_v[0] == 24'h000001 && dbg_v[0] == 4'd3) break;
      @(negedge clk);
    end
    chk("reach_wait_done", 32'(w < 500), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    run_one(0, 0, 24'h000003, 1'b1, 24'h000003, 1'b1, 4, 1'b0);

    // randomized runs checked against the reference model
    for (int r = 0; r < 16; r++) begin
      int j;
      logic [23:0] tg;
      j = int'($urandom_range(0, 2));
      if (j == 0) tg = 24'($urandom_range(0, 7));
      else tg = 24'hFFFFFE + 24'($urandom_range(0, 2));
      run_one(j, 5, tg, 1'b0, 24'h0, 1'b0, 0, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
